// File: rtl/event_pair_capture.sv
// event_pair_capture
//   Watches two asynchronous level inputs (in1, in2). After synchronisation,
//   every change of the {in1,in2} pair is stored with a free-running
//   timestamp in a small first-word-fall-through FIFO.
//
// Parameters
//   DEPTH : FIFO entries (power of two, 2..16)
//   TS_W  : timestamp width in bits
//
// Ports
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in1, in2  in   asynchronous level inputs (first / second of the pair)
//   clr       in   synchronous flush of FIFO, timestamp, overflow and FSM
//   out_valid out  head entry available
//   out_ready in   consumer accepts the head entry
//   out_data  out  {in1, in2, timestamp} of the head entry (0 while empty)
//   level     out  current FIFO occupancy, 0..DEPTH
//   overflow  out  sticky: at least one event was dropped
//   ovf_cnt   out  (only with EVENT_PAIR_CAPTURE_OVF_CNT_EN) saturating
//                  8-bit count of dropped events
//
// Build option
//   EVENT_PAIR_CAPTURE_OVF_CNT_EN : adds the ovf_cnt output and its counter.

module event_pair_capture #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in1,
  input  logic                       in2,
  input  logic                       clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TS_W+1:0]            out_data,
  output logic [$clog2(DEPTH):0]     level,
`ifdef EVENT_PAIR_CAPTURE_OVF_CNT_EN
  output logic [7:0]                 ovf_cnt,
`endif
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [1:0]        s1;
  logic [1:0]        s2;
  logic [1:0]        sync_fill;
  logic [1:0]        prev;
  logic [TS_W-1:0]   ts;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_reg;
  logic              overflow_reg;
  logic [TS_W+1:0]   mem [DEPTH];

  logic              event_hit;
  logic              pop;
  logic              full;
  logic              do_write;
  logic              drop;
  logic [LW-1:0]     level_next;

  assign event_hit  = (state == RUN) && (s2 != prev);
  assign out_valid  = (level_reg != '0);
  assign pop        = out_valid && out_ready;
  assign full       = (level_reg == LW'(DEPTH));
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_write   = event_hit && (!full || pop);
  assign drop       = event_hit && full && !pop;
  assign level_next = level_reg + LW'(do_write) - LW'(pop);

  assign level    = level_reg;
  assign overflow = overflow_reg;
  assign out_data = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1           <= '0;
      s2           <= '0;
      sync_fill    <= '0;
      prev         <= '0;
      state        <= PRIME;
      ts           <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      // Synchroniser runs regardless of clr.
      s1        <= {in1, in2};
      s2        <= s1;
      // sync_fill reaches 2'b11 once s2 holds a real sample of the pins
      // after reset, so PRIME never latches the reset value of s2 and pins
      // already high at reset release do not look like a change.
      sync_fill <= {sync_fill[0], 1'b1};

      if (clr) begin
        state        <= PRIME;
        ts           <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        level_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        ts <= ts + TS_W'(1);

        case (state)
          PRIME: begin
            prev <= s2;
            if (sync_fill == 2'b11) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (event_hit) begin
              prev <= s2;
            end
          end
          default: state <= PRIME;
        endcase

        if (do_write) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        level_reg <= level_next;
        if (drop) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: out_data is forced to 0 whenever empty.
  always_ff @(posedge clk) begin
    if (do_write && !clr) begin
      mem[wr_ptr] <= {s2, ts};
    end
  end

`ifdef EVENT_PAIR_CAPTURE_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (clr) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/event_pair_capture.md
EVENT_PAIR_CAPTURE -- requirements
Module: event_pair_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TS_W, default 8, timestamp width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port in1  input  1  asynchronous level input, first of pair.
REQ-006 SHALL have port in2  input  1  asynchronous level input, second of pair.
REQ-007 SHALL have port clr  input  1  synchronous flush: FIFO, timestamp, overflow, FSM.
REQ-008 SHALL have port out_valid  output  1  head entry available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-010 SHALL have port out_data  output  TS_W+2  {in1, in2, timestamp} of head entry, MSB first.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 SHALL synchronize in1 and in2 each through two flops (s1 then s2) before any use.
REQ-014 SHALL run a free-running TS_W-bit timestamp incrementing every cycle, wrapping from all-ones to 0.
REQ-015 SHALL implement FSM states PRIME and RUN; reset and clr enter PRIME.
REQ-016 PRIME: on the first cycle after entry, load prev pair from synchronized {in1,in2}, no event, go to RUN.
REQ-017 RUN: event when synchronized pair differs from prev; prev updated same edge.
REQ-018 On event SHALL push {pair, timestamp-at-that-edge}; push and prev update occur on the same edge.
REQ-019 Latency: pin change stable before edge N -> entry written at edge N+2 -> out_valid high after edge N+2 (FIFO empty).
REQ-020 FIFO SHALL be first-word-fall-through; out_data valid whenever out_valid high, stable until popped.
REQ-021 Pop occurs on edge where out_valid && out_ready; out_ready with FIFO empty has no effect.
REQ-022 Push when full and no pop: entry dropped, overflow set to 1, level stays DEPTH.
REQ-023 Push and pop same edge when full: both occur, no drop, level stays DEPTH.
REQ-024 Push and pop same edge when level 1: new entry becomes head next cycle, out_valid stays 1.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; level = writes - reads, 0..DEPTH.
REQ-026 clr SHALL take priority over push/pop that edge: level 0, out_valid 0, timestamp 0, overflow 0, state PRIME; synchronizer flops unaffected.
REQ-027 overflow SHALL remain set until clr or reset.

Reset
REQ-028 On rst_n low, asynchronously: out_valid 0, level 0, overflow 0, out_data 0, timestamp 0, s1/s2/prev 0, state PRIME.
REQ-029 Reset mid-operation SHALL discard all FIFO contents; no event emitted for pins already high at reset release.
REQ-030 FIFO storage array need not be reset; out_data SHALL read 0 while empty.

Configuration
REQ-031 With EVENT_PAIR_CAPTURE_OVF_CNT_EN defined: extra output ovf_cnt (8 bits) counts dropped events, saturates at 255, cleared by clr/reset.
REQ-032 Without EVENT_PAIR_CAPTURE_OVF_CNT_EN: port ovf_cnt and its counter absent; all other behaviour identical.

Verification
REQ-033 Reset release with in1=1,in2=1 held, out_ready=1, 20 cycles -> out_valid stays 0, level 0.
REQ-034 After priming at 00, in1 0->1 stable before edge N -> out_valid high after edge N+2, out_data[TS_W+1:TS_W]=2'b10, timestamp = value at edge N+2.
REQ-035 out_ready=0, DEPTH=4, five pair changes -> level 4, overflow 1, first four entries pop in order; with macro, ovf_cnt=1.
REQ-036 FIFO full, event coinciding with pop -> no drop, overflow stays 0, level stays 4, new entry last out.
REQ-037 Three entries queued, clr pulsed one cycle with out_ready=1 -> next cycle level 0, out_valid 0, timestamp 0, no pop counted; next pin change accepted after priming.
REQ-038 Timestamp wrap: TS_W=8, events at ts 254 and 1 (after wrap) -> entries carry 254 then 1.
